// File: rtl/pid_loop_sequencer.sv
// Control-loop sample sequencer: latches setpoint/process value once per sample,
// waits for the PID result with a timeout and converts it to a saturated PWM duty.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_IDLE       | loop disabled, PID held in reset, tick counter cleared
// S_WAIT_TICK  | counting out the sample period
// S_LOAD       | present new setpoint / process value to the PID
// S_WAIT_VALID | waiting for the PID result strobe, bounded by TIMEOUT
// S_SAT        | convert signed effort to duty magnitude + direction
module pid_loop_sequencer #(
  parameter int SAMPLE_DIV = 1000,
  parameter int TIMEOUT    = 64,
  parameter int DUTY_W     = 10,
  parameter int DUTY_MAX   = 1023
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic [15:0]       i_sp,
  input  logic              i_sp_valid,
  input  logic [15:0]       i_pv,
  output logic              o_pid_rst,
  output logic [15:0]       o_pid_sp,
  output logic [15:0]       o_pid_pv,
  input  logic [31:0]       i_pid_un,
  input  logic              i_pid_valid,
  output logic [DUTY_W-1:0] o_duty,
  output logic              o_dir,
  output logic              o_duty_valid,
  output logic              o_timeout_err,
  output logic              o_busy,
  output logic [15:0]       o_sample_cnt
);

  localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [DUTY_W-1:0] DUTY_SAT  = DUTY_W'(DUTY_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_TICK, S_LOAD, S_WAIT_VALID, S_SAT
  } state_t;

  state_t              r_state, w_next;
  logic [TICK_W-1:0]   r_tick;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [15:0]         r_sp_pend;
  logic [15:0]         r_pid_sp, r_pid_pv;
  logic [31:0]         r_un;
  logic [DUTY_W-1:0]   r_duty;
  logic                r_dir, r_duty_valid, r_timeout_err;
  logic [15:0]         r_sample_cnt;

  logic                w_tick_tc, w_wait_tc;
  logic [31:0]         w_mag;
  logic [DUTY_W-1:0]   w_duty_sat;

  assign w_tick_tc = (r_tick == TICK_LAST);
  assign w_wait_tc = (r_wait_cnt == WAIT_LAST);

  // 0x80000000 negates to itself, which as unsigned is 2^31 and saturates.
  assign w_mag      = r_un[31] ? (~r_un + 32'd1) : r_un;
  assign w_duty_sat = (w_mag > 32'(DUTY_MAX)) ? DUTY_SAT : w_mag[DUTY_W-1:0];

  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!i_enable) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:       w_next = S_WAIT_TICK;
        S_WAIT_TICK:  if (w_tick_tc) w_next = S_LOAD;
        S_LOAD:       w_next = S_WAIT_VALID;
        S_WAIT_VALID: begin
          if (i_pid_valid)    w_next = S_SAT;
          else if (w_wait_tc) w_next = S_WAIT_TICK;
        end
        S_SAT:        w_next = S_WAIT_TICK;
        default:      w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_tick        <= '0;
      r_wait_cnt    <= '0;
      r_sp_pend     <= '0;
      r_pid_sp      <= '0;
      r_pid_pv      <= '0;
      r_un          <= '0;
      r_duty        <= '0;
      r_dir         <= 1'b0;
      r_duty_valid  <= 1'b0;
      r_timeout_err <= 1'b0;
      r_sample_cnt  <= '0;
    end else begin
      r_duty_valid <= 1'b0;
      if (i_sp_valid) r_sp_pend <= i_sp;

      // Tick runs through LOAD/WAIT_VALID/SAT so the period ignores PID latency.
      if (!i_enable || r_state == S_IDLE) r_tick <= '0;
      else if (w_tick_tc)                 r_tick <= '0;
      else                                r_tick <= r_tick + TICK_ONE;

      if (!i_enable) begin
        if (r_duty != '0) begin
          r_duty       <= '0;
          r_dir        <= 1'b0;
          r_duty_valid <= 1'b1;
        end
      end else begin
        case (r_state)
          S_IDLE: r_timeout_err <= 1'b0;
          S_LOAD: begin
            r_pid_sp   <= i_sp_valid ? i_sp : r_sp_pend;
            r_pid_pv   <= i_pv;
            r_wait_cnt <= '0;
          end
          S_WAIT_VALID: begin
            if (i_pid_valid) begin
              r_un <= i_pid_un;
            end else if (w_wait_tc) begin
              r_timeout_err <= 1'b1;
              r_duty        <= '0;
              r_dir         <= 1'b0;
              r_duty_valid  <= 1'b1;
            end else begin
              r_wait_cnt <= r_wait_cnt + WAIT_ONE;
            end
          end
          S_SAT: begin
            r_dir        <= r_un[31];
            r_duty       <= w_duty_sat;
            r_duty_valid <= 1'b1;
            r_sample_cnt <= r_sample_cnt + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_pid_rst     = (r_state == S_IDLE);
  assign o_busy        = (r_state == S_LOAD) || (r_state == S_WAIT_VALID) || (r_state == S_SAT);
  assign o_pid_sp      = r_pid_sp;
  assign o_pid_pv      = r_pid_pv;
  assign o_duty        = r_duty;
  assign o_dir         = r_dir;
  assign o_duty_valid  = r_duty_valid;
  assign o_timeout_err = r_timeout_err;
  assign o_sample_cnt  = r_sample_cnt;

endmodule

// File: tb/tb_pid_loop_sequencer.sv
// Scoreboard bench for pid_loop_sequencer: a PID responder pushes expected duty
// results, a monitor pops and compares them on every o_duty_valid pulse.
module tb_pid_loop_sequencer;

  localparam int SAMPLE_DIV = 20;
  localparam int TIMEOUT    = 8;
  localparam int DUTY_W     = 10;
  localparam int DUTY_MAX   = 1023;

  logic              clk;
  logic              i_rst, i_enable, i_sp_valid, i_pid_valid;
  logic [15:0]       i_sp, i_pv;
  logic [31:0]       i_pid_un;
  logic              o_pid_rst, o_dir, o_duty_valid, o_timeout_err, o_busy;
  logic [15:0]       o_pid_sp, o_pid_pv, o_sample_cnt;
  logic [DUTY_W-1:0] o_duty;

  pid_loop_sequencer #(
    .SAMPLE_DIV(SAMPLE_DIV), .TIMEOUT(TIMEOUT), .DUTY_W(DUTY_W), .DUTY_MAX(DUTY_MAX)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_enable(i_enable),
    .i_sp(i_sp), .i_sp_valid(i_sp_valid), .i_pv(i_pv),
    .o_pid_rst(o_pid_rst), .o_pid_sp(o_pid_sp), .o_pid_pv(o_pid_pv),
    .i_pid_un(i_pid_un), .i_pid_valid(i_pid_valid),
    .o_duty(o_duty), .o_dir(o_dir), .o_duty_valid(o_duty_valid),
    .o_timeout_err(o_timeout_err), .o_busy(o_busy), .o_sample_cnt(o_sample_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int duty;
    bit dir;
    int cnt;
    bit err;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_pops  = 0;
  int          cyc     = 0;
  int          last_dv = -1;
  bit          period_on = 0;
  // PID responder controls
  bit          pid_respond = 1;
  bit          discard = 0;
  int          pid_lat = 3;
  logic [31:0] pid_un = 32'd150;
  int          exp_cnt = 0;
  bit          exp_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model_sat(input logic [31:0] un, input int cnt);
    exp_t e;
    longint m;
    m = $signed(un);
    if (m < 0) m = -m;
    e.duty = (m > DUTY_MAX) ? DUTY_MAX : int'(m);
    e.dir  = un[31];
    e.cnt  = cnt;
    e.err  = exp_err;
    return e;
  endfunction

  // PID responder: detects LOAD (rising o_busy) and either answers after pid_lat cycles or stays silent
  initial begin : pid_model
    bit busy_d;
    exp_t e;
    busy_d = 0;
    i_pid_valid = 0;
    i_pid_un = '0;
    forever begin
      @(negedge clk);
      if (o_busy && !busy_d) begin
        if (!pid_respond) begin
          if (!discard) begin
            e.duty = 0; e.dir = 0; e.cnt = exp_cnt; e.err = 1;
            exp_err = 1;
            sb.push_back(e);
          end
        end else begin
          repeat (pid_lat - 1) @(negedge clk);
          if (i_enable && i_rst && !discard) begin
            exp_cnt = (exp_cnt + 1) & 16'hFFFF;
            sb.push_back(model_sat(pid_un, exp_cnt));
          end
          i_pid_un = pid_un;
          i_pid_valid = 1;
          @(negedge clk);
          i_pid_valid = 0;
        end
      end
      busy_d = o_busy;
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_duty_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_dv", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("duty", o_duty, e.duty);
          chk("dir", o_dir, e.dir);
          chk("sample_cnt", o_sample_cnt, e.cnt);
          chk("timeout_err", o_timeout_err, e.err);
        end
        if (period_on && last_dv >= 0) chk("period", cyc - last_dv, SAMPLE_DIV);
        last_dv = cyc;
        n_pops++;
      end
    end
  end

  initial begin : pv_ramp
    i_pv = 16'd100;
    forever begin
      repeat (10) @(posedge clk);
      #2 i_pv = i_pv + 16'd30;
    end
  end

  task automatic wait_pops(input int k);
    int target;
    int budget;
    target = n_pops + k;
    budget = 0;
    while (n_pops < target && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (n_pops < target) chk("wait_dv_timeout", n_pops, target);
  endtask

  task automatic wait_load();
    int budget;
    budget = 0;
    while (o_busy && budget < 100) begin @(negedge clk); budget++; end
    while (!o_busy && budget < 100) begin @(negedge clk); budget++; end
    if (!o_busy) chk("wait_load_timeout", 0, 1);
  endtask

  initial begin : main
    logic [31:0] un_tab[7];
    logic [15:0] exp_pv;
    int bad;
    un_tab = '{32'hFFFF_EC78, 32'h8000_0000, 32'd1023, 32'd1024,
               32'hFFFF_FFFF, 32'd0, 32'd5000};
    i_rst = 0; i_enable = 0; i_sp = '0; i_sp_valid = 0;
    repeat (3) @(negedge clk);
    chk("rst_pid_rst", o_pid_rst, 1);
    chk("rst_duty", o_duty, 0);
    chk("rst_dir", o_dir, 0);
    chk("rst_dv", o_duty_valid, 0);
    chk("rst_err", o_timeout_err, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_cnt", o_sample_cnt, 0);
    chk("rst_sp", o_pid_sp, 0);
    chk("rst_pv", o_pid_pv, 0);

    // steady loop, un=+150, three samples
    i_rst = 1; i_enable = 1;
    @(negedge clk);
    chk("run_pid_rst", o_pid_rst, 0);
    wait_pops(1);
    period_on = 1;
    wait_pops(2);
    chk("cnt_after3", o_sample_cnt, 3);

    // saturation and sign table
    foreach (un_tab[i]) begin
      pid_un = un_tab[i];
      wait_pops(1);
    end
    period_on = 0;

    // PID silent -> timeout
    pid_respond = 0;
    wait_pops(1);
    chk("err_sticky", o_timeout_err, 1);
    i_enable = 0;
    repeat (2) @(negedge clk);
    pid_respond = 1; pid_un = 32'd150;
    exp_err = 0; i_enable = 1;
    @(negedge clk);
    chk("err_cleared", o_timeout_err, 0);

    // setpoint bypass and process-value hold
    wait_pops(1);
    @(negedge clk);
    i_sp = 16'd450; i_sp_valid = 1;
    @(negedge clk);
    i_sp_valid = 0;
    wait_load();
    i_sp = 16'd600; i_sp_valid = 1;
    exp_pv = i_pv;
    @(negedge clk);
    i_sp_valid = 0;
    chk("pid_sp_bypass", o_pid_sp, 600);
    chk("pid_pv_load", o_pid_pv, exp_pv);
    bad = 0;
    repeat (18) begin
      @(negedge clk);
      if (o_pid_pv !== exp_pv) bad++;
    end
    chk("pid_pv_stable", bad, 0);

    // enable dropped mid-WAIT_VALID with duty=300
    pid_un = 32'd300;
    wait_pops(1);
    chk("duty_300", o_duty, 300);
    pid_lat = 6;
    wait_load();
    @(negedge clk);
    i_enable = 0;
    sb.push_back('{duty: 0, dir: 0, cnt: exp_cnt, err: 0});
    @(negedge clk);
    chk("drop_pid_rst", o_pid_rst, 1);
    chk("drop_busy", o_busy, 0);
    repeat (10) @(negedge clk);
    chk("drop_sb_empty", sb.size(), 0);
    chk("drop_cnt_hold", o_sample_cnt, exp_cnt);
    chk("drop_duty", o_duty, 0);

    // reset mid-WAIT_VALID
    pid_lat = 3; pid_un = 32'd300; i_enable = 1;
    wait_pops(1);
    discard = 1; pid_lat = 6;
    wait_load();
    @(negedge clk);
    i_rst = 0; i_enable = 0;
    @(negedge clk);
    chk("mrst_pid_rst", o_pid_rst, 1);
    chk("mrst_duty", o_duty, 0);
    chk("mrst_dv", o_duty_valid, 0);
    chk("mrst_busy", o_busy, 0);
    chk("mrst_cnt", o_sample_cnt, 0);
    chk("mrst_sp", o_pid_sp, 0);
    chk("mrst_pv", o_pid_pv, 0);
    repeat (8) @(negedge clk);
    i_rst = 1;
    repeat (10) @(negedge clk);
    chk("final_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
